// File: rtl/cve2_pwr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cve2_pwr_ctrl: per-hart idle detection, clock-gate enable and wake counters |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cve2_pwr_ctrl #(
  parameter int unsigned NumHarts       = 2,
  parameter int unsigned IdleHoldCycles = 4,
  parameter int unsigned WakeDelay      = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumHarts-1:0]      core_busy_i,
  input  logic [NumHarts-1:0]      irq_pending_i,
  input  logic [NumHarts-1:0]      irq_nm_i,
  input  logic [NumHarts-1:0]      debug_req_i,
  input  logic                     cnt_clr_i,
  output logic [NumHarts-1:0]      clk_en_o,
  output logic [NumHarts-1:0]      core_sleep_o,
  output logic                     all_sleep_o,
  output logic [16*NumHarts-1:0]   wake_cnt_o
);

  localparam int unsigned MaxCnt = (IdleHoldCycles > WakeDelay) ? IdleHoldCycles : WakeDelay;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt + 1) : 1;
  localparam logic [CntW-1:0] IdleLast = CntW'(IdleHoldCycles - 1);
  localparam logic [CntW-1:0] WakeLast = CntW'(WakeDelay - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IDLE_WAIT = 2'd1,
    SLEEP     = 2'd2,
    WAKE      = 2'd3
  } pwr_state_e;

  logic [NumHarts-1:0] w_wake_src;
  assign w_wake_src = irq_pending_i | irq_nm_i | debug_req_i;

  for (genvar h = 0; h < NumHarts; h++) begin : g_hart
    pwr_state_e      r_state;
    logic [CntW-1:0] r_cnt;
    logic [15:0]     r_wake_cnt;
    logic            r_clk_en;
    logic            r_sleep;

    // Outputs are decoded from the next state so they stay registered yet aligned with r_state.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state    <= RUN;
        r_cnt      <= '0;
        r_wake_cnt <= '0;
        r_clk_en   <= 1'b1;
        r_sleep    <= 1'b0;
      end else begin
        case (r_state)
          RUN: begin
            if (!core_busy_i[h] && !w_wake_src[h]) begin
              if (IdleHoldCycles == 0) begin
                r_state  <= SLEEP;
                r_clk_en <= 1'b0;
                r_sleep  <= 1'b1;
              end else begin
                r_state <= IDLE_WAIT;
                r_cnt   <= '0;
              end
            end
          end
          IDLE_WAIT: begin
            if (core_busy_i[h] || w_wake_src[h]) begin
              r_state <= RUN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == IdleLast) begin
                r_state  <= SLEEP;
                r_clk_en <= 1'b0;
                r_sleep  <= 1'b1;
              end
            end
          end
          SLEEP: begin
            if (w_wake_src[h]) begin
              r_sleep <= 1'b0;
              if (WakeDelay == 0) begin
                r_state  <= RUN;
                r_clk_en <= 1'b1;
              end else begin
                r_state <= WAKE;
                r_cnt   <= '0;
              end
            end
          end
          WAKE: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == WakeLast) begin
              r_state  <= RUN;
              r_clk_en <= 1'b1;
            end
          end
          default: begin
            r_state  <= RUN;
            r_clk_en <= 1'b1;
            r_sleep  <= 1'b0;
          end
        endcase

        // Clear takes precedence over a coincident wake; the count saturates.
        if (cnt_clr_i) begin
          r_wake_cnt <= '0;
        end else if ((r_state == SLEEP) && w_wake_src[h] && (r_wake_cnt != 16'hFFFF)) begin
          r_wake_cnt <= r_wake_cnt + 16'd1;
        end
      end
    end

    assign clk_en_o[h]          = r_clk_en;
    assign core_sleep_o[h]      = r_sleep;
    assign wake_cnt_o[16*h +: 16] = r_wake_cnt;
  end

  assign all_sleep_o = &core_sleep_o;

endmodule
`default_nettype wire

// File: tb/tb_cve2_pwr_ctrl.sv
`default_nettype none
// Directed self-checking bench for cve2_pwr_ctrl (NumHarts=2, IdleHoldCycles=4, WakeDelay=2).
module tb_cve2_pwr_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  core_busy_i;
  logic [1:0]  irq_pending_i;
  logic [1:0]  irq_nm_i;
  logic [1:0]  debug_req_i;
  logic        cnt_clr_i;
  logic [1:0]  clk_en_o;
  logic [1:0]  core_sleep_o;
  logic        all_sleep_o;
  logic [31:0] wake_cnt_o;

  int checks = 0;
  int errors = 0;

  cve2_pwr_ctrl #(
    .NumHarts(2),
    .IdleHoldCycles(4),
    .WakeDelay(2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .core_busy_i  (core_busy_i),
    .irq_pending_i(irq_pending_i),
    .irq_nm_i     (irq_nm_i),
    .debug_req_i  (debug_req_i),
    .cnt_clr_i    (cnt_clr_i),
    .clk_en_o     (clk_en_o),
    .core_sleep_o (core_sleep_o),
    .all_sleep_o  (all_sleep_o),
    .wake_cnt_o   (wake_cnt_o)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; core_busy_i = 2'b11; irq_pending_i = '0; irq_nm_i = '0;
    debug_req_i = '0; cnt_clr_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    tick();
    checks++;
    if ({clk_en_o, core_sleep_o, all_sleep_o} !== 5'b11_00_0) begin
      errors++;
      $display("FAIL reset_outputs: got clk_en=%b sleep=%b all=%b, expected 11 00 0",
               clk_en_o, core_sleep_o, all_sleep_o);
    end
    checks++;
    if (wake_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_wake_cnt: got %h expected 00000000", wake_cnt_o);
    end
  endtask

  task automatic test_aborted_idle();
    core_busy_i[0] = 1'b0;
    tick(); tick();
    core_busy_i[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (clk_en_o[0] !== 1'b1 || core_sleep_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL aborted_idle step %0d: got clk_en0=%b sleep0=%b expected 1 0",
                 i, clk_en_o[0], core_sleep_o[0]);
      end
      tick();
    end
  endtask

  task automatic test_idle_entry();
    core_busy_i[0] = 1'b0;
    // Offset 0 is cycle T; hart0 must gate from T+5.
    for (int k = 0; k <= 6; k++) begin
      checks++;
      if (clk_en_o[0] !== (k < 5) || core_sleep_o[0] !== (k >= 5) || clk_en_o[1] !== 1'b1) begin
        errors++;
        $display("FAIL idle_entry T+%0d: got clk_en=%b sleep0=%b expected clk_en0=%0d clk_en1=1 sleep0=%0d",
                 k, clk_en_o, core_sleep_o[0], (k < 5), (k >= 5));
      end
      if (k < 6) tick();
    end
  endtask

  task automatic test_wake();
    irq_pending_i[0] = 1'b1;
    tick();
    irq_pending_i[0] = 1'b0;
    core_busy_i[0] = 1'b1;
    checks++;
    if (core_sleep_o[0] !== 1'b0 || clk_en_o[0] !== 1'b0 || wake_cnt_o[15:0] !== 16'd1) begin
      errors++;
      $display("FAIL wake_S+1: got sleep0=%b clk_en0=%b cnt0=%0d expected 0 0 1",
               core_sleep_o[0], clk_en_o[0], wake_cnt_o[15:0]);
    end
    tick();
    checks++;
    if (clk_en_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL wake_S+2: got clk_en0=%b expected 0", clk_en_o[0]);
    end
    tick();
    checks++;
    if (clk_en_o[0] !== 1'b1 || core_sleep_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL wake_S+3: got clk_en0=%b sleep0=%b expected 1 0", clk_en_o[0], core_sleep_o[0]);
    end
  endtask

  task automatic test_both_harts();
    core_busy_i = 2'b00;
    repeat (5) tick();
    checks++;
    if (core_sleep_o !== 2'b11 || all_sleep_o !== 1'b1 || clk_en_o !== 2'b00) begin
      errors++;
      $display("FAIL both_sleep: got sleep=%b all=%b clk_en=%b expected 11 1 00",
               core_sleep_o, all_sleep_o, clk_en_o);
    end
    core_busy_i = 2'b11;
    tick();
    checks++;
    if (core_sleep_o !== 2'b11) begin
      errors++;
      $display("FAIL busy_in_sleep: got sleep=%b expected 11", core_sleep_o);
    end
    debug_req_i[1] = 1'b1;
    irq_nm_i[0]    = 1'b1;
    tick();
    debug_req_i = '0;
    irq_nm_i    = '0;
    checks++;
    if (all_sleep_o !== 1'b0 || core_sleep_o !== 2'b00 || clk_en_o !== 2'b00) begin
      errors++;
      $display("FAIL both_wake: got all=%b sleep=%b clk_en=%b expected 0 00 00",
               all_sleep_o, core_sleep_o, clk_en_o);
    end
    checks++;
    if (wake_cnt_o !== {16'd1, 16'd2}) begin
      errors++;
      $display("FAIL both_wake_cnt: got %h expected 00010002", wake_cnt_o);
    end
    tick(); tick();
    checks++;
    if (clk_en_o !== 2'b11) begin
      errors++;
      $display("FAIL both_resume: got clk_en=%b expected 11", clk_en_o);
    end
  endtask

  task automatic test_saturation_clear();
    core_busy_i[0] = 1'b0;
    repeat (5) tick();
    checks++;
    if (core_sleep_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL sat_sleep: got sleep0=%b expected 1", core_sleep_o[0]);
    end
    // Preload stands in for 65534 earlier wakes.
    force dut.g_hart[0].r_wake_cnt = 16'hFFFE;
    #1;
    release dut.g_hart[0].r_wake_cnt;
    irq_pending_i[0] = 1'b1;
    tick();
    irq_pending_i[0] = 1'b0;
    checks++;
    if (wake_cnt_o[15:0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: got %h expected ffff", wake_cnt_o[15:0]);
    end
    repeat (7) tick();
    checks++;
    if (core_sleep_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL sat_resleep: got sleep0=%b expected 1", core_sleep_o[0]);
    end
    irq_pending_i[0] = 1'b1;
    tick();
    irq_pending_i[0] = 1'b0;
    checks++;
    if (wake_cnt_o[15:0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h expected ffff", wake_cnt_o[15:0]);
    end
    repeat (7) tick();
    irq_pending_i[0] = 1'b1;
    cnt_clr_i = 1'b1;
    tick();
    irq_pending_i[0] = 1'b0;
    cnt_clr_i = 1'b0;
    checks++;
    if (wake_cnt_o !== 32'h0 || core_sleep_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins: got cnt=%h sleep0=%b expected 00000000 0", wake_cnt_o, core_sleep_o[0]);
    end
  endtask

  task automatic test_reset_mid_wake();
    repeat (7) tick();
    irq_pending_i[0] = 1'b1;
    tick();
    irq_pending_i[0] = 1'b0;
    checks++;
    if (clk_en_o[0] !== 1'b0 || wake_cnt_o[15:0] !== 16'd1) begin
      errors++;
      $display("FAIL pre_reset_wake: got clk_en0=%b cnt0=%0d expected 0 1", clk_en_o[0], wake_cnt_o[15:0]);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if (clk_en_o !== 2'b11 || core_sleep_o !== 2'b00 || wake_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_wake: got clk_en=%b sleep=%b cnt=%h expected 11 00 00000000",
               clk_en_o, core_sleep_o, wake_cnt_o);
    end
    tick();
    checks++;
    if (clk_en_o !== 2'b11 || core_sleep_o !== 2'b00 || all_sleep_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_hold: got clk_en=%b sleep=%b all=%b expected 11 00 0",
               clk_en_o, core_sleep_o, all_sleep_o);
    end
  endtask

  initial begin
    test_reset();
    test_aborted_idle();
    test_idle_entry();
    test_wake();
    test_both_harts();
    test_saturation_clear();
    test_reset_mid_wake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
